// File: rtl/vc4000_cart_loader.sv
// Cartridge download sequencer: buffers ioctl bytes into the cartridge RAM, zero-fills
// the remainder, publishes size/mirror mask and holds the core in reset meanwhile.
module vc4000_cart_loader #(
   parameter int         ADDR_W     = 13,
   parameter logic [7:0] INDEX      = 8'd0,
   parameter int         RESET_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_we,
   input  logic [7:0]        ram_dout,
   output logic              core_reset,
   output logic [ADDR_W:0]   cart_size,
   output logic [ADDR_W-1:0] cart_mask,
   output logic              overflow
);

   localparam int              CNT_W     = $clog2(RESET_HOLD + 1);
   localparam logic [ADDR_W:0] FULL_SIZE = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {HOLD, RUN, LOAD, FILL} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  hold_cnt;
   logic [ADDR_W-1:0] fill_addr;
   logic              vld_p1;
   logic              ovf_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [7:0]        data_p1;

   logic              dl_start;
   logic              wr_ovf;
   logic [ADDR_W:0]   wr_size;
   logic              load_done;

   // Smear the highest set bit of (size-1) downwards to get the next 2^k-1.
   function automatic logic [ADDR_W-1:0] mirror_mask(input logic [ADDR_W:0] size);
      logic [ADDR_W:0] m;
      if (size == '0)
         return '1;
      m = size - (ADDR_W+1)'(1);
      for (int i = 1; i <= ADDR_W; i++)
         m = m | (m >> i);
      return m[ADDR_W-1:0];
   endfunction

   assign dl_start  = ioctl_download && (ioctl_index == INDEX) && (state != LOAD);
   assign wr_ovf    = |ioctl_addr[24:ADDR_W];
   assign wr_size   = wr_ovf ? FULL_SIZE
                             : ({1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1));
   // A pending buffered byte must reach the RAM before the fill takes the port.
   assign load_done = (state == LOAD) && !ioctl_download && !vld_p1 && !ioctl_wr;

   assign ioctl_wait = vld_p1;
   assign cart_mask  = mirror_mask(cart_size);

   always_comb begin
      state_nxt  = state;
      core_reset = 1'b1;
      cpu_data   = 8'hFF;
      ram_addr   = cpu_addr;
      ram_din    = 8'h00;
      ram_we     = 1'b0;
      case (state)
         HOLD: if (hold_cnt == CNT_W'(RESET_HOLD - 1)) state_nxt = RUN;
         RUN: begin
            core_reset = 1'b0;
            cpu_data   = ram_dout;
         end
         LOAD: begin
            ram_addr = addr_p1;
            ram_din  = data_p1;
            ram_we   = vld_p1 && !ovf_p1;
            if (load_done)
               state_nxt = cart_size[ADDR_W] ? HOLD : FILL;
         end
         FILL: begin
            ram_addr = fill_addr;
            ram_we   = 1'b1;
            if (&fill_addr) state_nxt = HOLD;
         end
         default: state_nxt = HOLD;
      endcase
      if (dl_start)
         state_nxt = LOAD;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HOLD;
         hold_cnt  <= '0;
         fill_addr <= '0;
         vld_p1    <= 1'b0;
         cart_size <= '0;
         overflow  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= (state == HOLD && state_nxt == HOLD) ? hold_cnt + CNT_W'(1) : '0;
         if (state_nxt == FILL && state != FILL)
            fill_addr <= cart_size[ADDR_W-1:0];
         else if (state == FILL)
            fill_addr <= fill_addr + ADDR_W'(1);
         if (dl_start) begin
            vld_p1    <= 1'b0;
            cart_size <= '0;
            overflow  <= 1'b0;
         end else begin
            vld_p1 <= (state == LOAD) && ioctl_wr;
            if (state == LOAD && ioctl_wr) begin
               if (wr_ovf)
                  overflow <= 1'b1;
               if (wr_size > cart_size)
                  cart_size <= wr_size;
            end
         end
      end
   end

   // Stage p1: one-entry write buffer, qualified by vld_p1.
   always_ff @(posedge clk) begin
      if (ioctl_wr) begin
         addr_p1 <= ioctl_addr[ADDR_W-1:0];
         data_p1 <= ioctl_dout;
         ovf_p1  <= wr_ovf;
      end
   end

endmodule

// File: tb/tb_vc4000_cart_loader.sv
// Randomized bench for vc4000_cart_loader against a byte-array model of the cartridge RAM.
module tb_vc4000_cart_loader;

   localparam int RAM_SZ = 8192;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic [12:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;
   logic        core_reset;
   logic [13:0] cart_size;
   logic [12:0] cart_mask;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   bit [7:0] mem     [0:RAM_SZ-1];
   bit [7:0] ref_mem [0:RAM_SZ-1];
   int       m_size;
   bit       m_ovf;

   always #5 clk = ~clk;

   vc4000_cart_loader dut (
      .clk(clk), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
      .core_reset(core_reset), .cart_size(cart_size), .cart_mask(cart_mask),
      .overflow(overflow)
   );

   // Synchronous single-port cartridge RAM, 1-cycle read latency.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_mask(input int size);
      if (size == 0) return RAM_SZ - 1;
      for (int k = 0; k <= 13; k++)
         if ((1 << k) >= size) return (1 << k) - 1;
      return RAM_SZ - 1;
   endfunction

   task automatic check_reset_values();
      check("rst_core_reset", core_reset, 1);
      check("rst_ram_we", ram_we, 0);
      check("rst_ioctl_wait", ioctl_wait, 0);
      check("rst_cart_size", cart_size, 0);
      check("rst_cart_mask", cart_mask, 13'h1FFF);
      check("rst_overflow", overflow, 0);
      check("rst_cpu_data", cpu_data, 8'hFF);
   endtask

   task automatic count_hold();
      int hold = 0;
      while (core_reset && hold < 100) begin
         hold++;
         @(posedge clk); #1;
      end
      check("hold_len", hold, 16);
      check("run_core_reset", core_reset, 0);
   endtask

   task automatic cpu_read(input int addr, input logic [7:0] exp);
      @(negedge clk);
      cpu_addr = 13'(addr);
      @(posedge clk); #1;
      check("cpu_read", cpu_data, exp);
   endtask

   task automatic start_dl();
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_index    = 8'd0;
      m_size = 0;
      m_ovf  = 1'b0;
      @(posedge clk); #1;
      check("load_core_reset", core_reset, 1);
      check("load_cart_size", cart_size, 0);
      check("load_overflow", overflow, 0);
      check("load_cpu_data", cpu_data, 8'hFF);
      check("load_wait", ioctl_wait, 0);
   endtask

   task automatic do_write(input int addr, input logic [7:0] data);
      int sz;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      @(negedge clk);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(addr);
      ioctl_dout = data;
      if (addr < RAM_SZ) ref_mem[addr] = data;
      else m_ovf = 1'b1;
      sz = (addr >= RAM_SZ) ? RAM_SZ : addr + 1;
      if (sz > m_size) m_size = sz;
      @(posedge clk); #1;
      check("wr_wait", ioctl_wait, 1);
      check("wr_we", ram_we, (addr < RAM_SZ) ? 1 : 0);
      check("wr_overflow", overflow, m_ovf);
      if (addr < RAM_SZ) begin
         check("wr_addr", ram_addr, addr);
         check("wr_din", ram_din, data);
      end
      @(negedge clk);
      ioctl_wr = 1'b0;
      @(posedge clk); #1;
      check("wr_wait_clr", ioctl_wait, 0);
      check("wr_we_clr", ram_we, 0);
      check("wr_cart_size", cart_size, m_size);
      check("wr_cart_mask", cart_mask, model_mask(m_size));
   endtask

   task automatic finish_load();
      int  fills = 0;
      int  exp_addr = m_size;
      bit  done = 1'b0;
      @(negedge clk);
      ioctl_download = 1'b0;
      for (int c = 0; c < 9000 && !done; c++) begin
         @(posedge clk); #1;
         if (ram_we) begin
            check("fill_addr", ram_addr, exp_addr);
            check("fill_din", ram_din, 0);
            exp_addr++;
            fills++;
         end else begin
            done = 1'b1;
         end
      end
      check("fill_len", fills, RAM_SZ - m_size);
      check("final_cart_size", cart_size, m_size);
      check("final_cart_mask", cart_mask, model_mask(m_size));
      for (int a = m_size; a < RAM_SZ; a++) ref_mem[a] = 8'h00;
      count_hold();
   endtask

   task automatic check_image();
      int bad = 0;
      for (int a = 0; a < RAM_SZ; a++)
         if (mem[a] != ref_mem[a]) bad++;
      check("ram_image", bad, 0);
   endtask

   initial begin
      int lim, n, a;
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      cpu_addr       = '0;
      #1;
      check_reset_values();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1;
      count_hold();
      for (int i = 0; i < 4; i++) cpu_read($urandom_range(0, RAM_SZ - 1), 8'h00);

      // Contiguous 2048-byte cartridge
      start_dl();
      for (int i = 0; i < 2048; i++) do_write(i, 8'(i));
      finish_load();
      check("size_2048", cart_size, 2048);
      check("mask_2048", cart_mask, 13'h07FF);
      check_image();
      for (int i = 0; i < 8; i++) begin
         a = $urandom_range(0, RAM_SZ - 1);
         cpu_read(a, ref_mem[a]);
      end

      // Foreign index while running: ignored
      @(negedge clk);
      ioctl_download = 1'b1;
      ioctl_index    = 8'd1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ioctl_wr   = ~ioctl_wr;
         ioctl_addr = 25'($urandom_range(0, RAM_SZ - 1));
         @(posedge clk); #1;
         check("idx1_we", ram_we, 0);
         check("idx1_core_reset", core_reset, 0);
      end
      @(negedge clk);
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      @(posedge clk); #1;
      check("idx1_cart_size", cart_size, 2048);

      // 3000-byte cartridge
      start_dl();
      for (int i = 0; i < 3000; i++) do_write(i, 8'(i));
      finish_load();
      check("mask_3000", cart_mask, 13'h0FFF);
      cpu_read(2999, 8'hB7);
      cpu_read(3000, 8'h00);
      check_image();

      // Sparse random cartridges
      for (int it = 0; it < 2; it++) begin
         lim = 1 << $urandom_range(1, 12);
         n   = $urandom_range(1, 30);
         start_dl();
         for (int i = 0; i < n; i++) do_write($urandom_range(0, lim - 1), 8'($urandom));
         finish_load();
         check_image();
         a = $urandom_range(0, RAM_SZ - 1);
         cpu_read(a, ref_mem[a]);
      end

      // Out-of-range write: overflow, saturated size, no fill
      start_dl();
      do_write(10, 8'($urandom));
      do_write(RAM_SZ + $urandom_range(0, 100), 8'h5A);
      do_write(20, 8'($urandom));
      check("ovf_flag", overflow, 1);
      check("ovf_size", cart_size, RAM_SZ);
      finish_load();
      check_image();

      // Async reset in the middle of FILL
      start_dl();
      for (int i = 0; i < 100; i++) do_write(i, 8'($urandom));
      @(negedge clk);
      ioctl_download = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         check("fill_active", ram_we, 1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      count_hold();

      // Full reload makes the whole RAM defined again
      start_dl();
      for (int i = 0; i < 500; i++) do_write(i, 8'($urandom));
      finish_load();
      check_image();
      a = $urandom_range(0, 499);
      cpu_read(a, ref_mem[a]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
